div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative RV32M divider in the execute stage: DIV, DIVU, REM, REMU.
- Consumes the forwarded rs1/rs2 operands produced by the operand-forwarding logic, together with the destination register address.
- Uses a radix-2 restoring algorithm that retires one quotient bit per cycle.
- Raises a stall request so the pipeline holds the divide instruction in execute until the result is ready.

Parameters:
- DW, `XLEN (32): operand/result width; the iteration count equals DW.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start_i  input  1  divide instruction present in execute; sampled only in IDLE
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend_i  input  DW  forwarded rs1 data
- divisor_i  input  DW  forwarded rs2 data
- rd_addr_i  input  5  destination register
- flush_i  input  1  pipeline flush (branch/trap); aborts the operation
- busy_o  output  1  iteration in progress
- valid_o  output  1  one-cycle result strobe
- result_o  output  DW  quotient or remainder
- rd_addr_o  output  5  destination register for result_o
- stall_req_o  output  1  hold the pipeline (combinational)

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; busy_o=0, valid_o=0, result_o=0, rd_addr_o=0, and all internal registers cleared. A reset mid-operation abandons the operation with no valid_o.
- States:
  - IDLE → CALC when start_i=1 and no special case applies; latch the operands and op.
  - IDLE → DONE when start_i=1 and a special case applies.
  - CALC → DONE after DW iterations.
  - DONE → IDLE unconditionally.
- Operand capture:
  - Signed ops (DIV, REM) capture absolute values, plus sign_q = dividend[DW-1]^divisor[DW-1] and sign_r = dividend[DW-1].
  - Unsigned ops capture raw values.
  - Input changes after the start edge are ignored.
- Iteration (CALC): each cycle, shift {rem,quo} left by 1 and trial-subtract the divisor. If there is no borrow, keep the difference and set the quotient LSB to 1; otherwise restore. The remainder register is DW+1 bits wide.
- Sign fix at CALC→DONE: negate the quotient if sign_q=1, and negate the remainder if sign_r=1. The remainder takes the dividend's sign.
- Special cases (resolved combinationally in IDLE, no iterations):
  - divisor==0: DIV/DIVU → all ones; REM/REMU → dividend.
  - DIV with dividend=0x80000000 and divisor=0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
- Timing, with start_i sampled high in cycle 0:
  - Normal path: busy_o=1 in cycles 1..DW; valid_o=1 in cycle DW+1 only.
  - Special case: valid_o=1 in cycle 1; busy_o stays 0.
- result_o and rd_addr_o are registered at the DONE transition and hold their value until the next completion.
- stall_req_o = (state==IDLE & start_i & !flush_i) | (state==CALC).
  - Low in the DONE cycle so the instruction leaves execute exactly when valid_o=1.
  - A new start_i is only sampled once the state is back in IDLE, so back-to-back divides are accepted with one cycle between valid_o and the next start.
- flush_i:
  - Any state, next state is IDLE.
  - A pending valid_o is suppressed and result_o/rd_addr_o are not updated.
  - Flush has priority over start_i in the same cycle.
  - flush_i in DONE: valid_o in that cycle remains asserted, because the output is already registered. The pipeline is responsible for squashing it.
- Arithmetic is modulo 2^DW with no exceptions raised.

Test Plan:
- DIVU 100/7, rd=5 → valid_o in cycle 33, result_o=14 (0x0000000E), rd_addr_o=5, busy_o high for exactly cycles 1..32; repeat as REMU → result_o=2.
- DIV 0xFFFFFFF9/2 (-7/2) → result_o=0xFFFFFFFD (-3); REM same operands → 0xFFFFFFFF (-1); REM 7/0xFFFFFFFE (7/-2) → 1.
- Divide by zero: DIVU 0x1234/0 → valid_o in cycle 1, result_o=0xFFFFFFFF, busy_o never high; REM 0x1234/0 → 0x00001234.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000 in cycle 1; REM same operands → 0.
- Flush: start DIVU 1000/3, assert flush_i in cycle 10 → IDLE in cycle 11, no valid_o, result_o keeps its previous value; start DIVU 9/3 in cycle 11 → result_o=3 in cycle 44.
- Reset and stall: assert rst in cycle 5 of an operation → all outputs 0 next cycle; stall_req_o is high in cycles 0..32 and low in cycle 33 for a normal divide.

Source files
------------

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Purpose  : Iterative RV32M divider (DIV, DIVU, REM, REMU) for the execute
//             stage. Radix-2 restoring division, one quotient bit per cycle.
//             Divide-by-zero and signed overflow complete without iterating.
//             Requests a pipeline stall while the instruction is held.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             start_i           - divide present in execute (sampled in IDLE)
//             op_i              - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//             dividend_i        - forwarded rs1 data
//             divisor_i         - forwarded rs2 data
//             rd_addr_i         - destination register
//             flush_i           - pipeline flush, aborts the operation
//             busy_o            - iteration in progress
//             valid_o           - one-cycle result strobe
//             result_o          - quotient or remainder
//             rd_addr_o         - destination register for result_o
//             stall_req_o       - combinational pipeline hold request
//  Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  input  logic [4:0]    rd_addr_i,
  input  logic          flush_i,
  output logic          busy_o,
  output logic          valid_o,
  output logic [DW-1:0] result_o,
  output logic [4:0]    rd_addr_o,
  output logic          stall_req_o
);

  localparam int            CW        = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] C_LAST    = CW'(DW - 1);
  localparam logic [DW-1:0] C_INT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [DW:0]   rem_q;
  logic [DW-1:0] quo_q;
  logic [DW-1:0] dvsr_q;
  logic          neg_quo_q;
  logic          neg_rem_q;
  logic          is_rem_q;
  logic [4:0]    rd_q;
  logic [DW-1:0] result_q;
  logic [4:0]    rd_out_q;

  // ---------------- operand decode (IDLE) ----------------
  logic          w_signed, w_is_rem, w_div_zero, w_ovf, w_special, w_accept;
  logic          w_dvd_neg, w_dvs_neg;
  logic [DW-1:0] w_dvd_abs, w_dvs_abs, w_special_res;

  assign w_signed   = ~op_i[0];
  assign w_is_rem   = op_i[1];
  assign w_div_zero = (divisor_i == '0);
  assign w_ovf      = w_signed & (dividend_i == C_INT_MIN) & (divisor_i == '1);
  assign w_special  = w_div_zero | w_ovf;
  assign w_accept   = (state_q == S_IDLE) & start_i & ~flush_i;

  assign w_dvd_neg  = w_signed & dividend_i[DW-1];
  assign w_dvs_neg  = w_signed & divisor_i[DW-1];
  // |INT_MIN| wraps to INT_MIN, which is the correct magnitude when read unsigned.
  assign w_dvd_abs  = w_dvd_neg ? -dividend_i : dividend_i;
  assign w_dvs_abs  = w_dvs_neg ? -divisor_i  : divisor_i;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = w_is_rem ? dividend_i : '1;
    end else begin
      w_special_res = w_is_rem ? '0 : C_INT_MIN;
    end
  end

  // ---------------- restoring iteration ----------------
  // The partial remainder never reaches 2*divisor, so the top bit of the
  // DW+2 bit difference is a clean borrow flag.
  logic [DW+1:0] w_shift, w_diff;
  logic          w_borrow;
  logic [DW:0]   w_rem_nx;
  logic [DW-1:0] w_quo_nx, w_rem_lo, w_quo_fix, w_rem_fix;

  assign w_shift   = {rem_q, quo_q[DW-1]};
  assign w_diff    = w_shift - {2'b00, dvsr_q};
  assign w_borrow  = w_diff[DW+1];
  assign w_rem_nx  = w_borrow ? w_shift[DW:0] : w_diff[DW:0];
  assign w_quo_nx  = {quo_q[DW-2:0], ~w_borrow};
  assign w_rem_lo  = w_rem_nx[DW-1:0];
  assign w_quo_fix = neg_quo_q ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix = neg_rem_q ? -w_rem_lo : w_rem_lo;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = w_special ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == C_LAST) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything, including a same-cycle start.
    if (flush_i) state_d = S_IDLE;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else if (w_accept) begin
      if (w_special) begin
        result_q <= w_special_res;
        rd_out_q <= rd_addr_i;
      end else begin
        cnt_q     <= '0;
        rem_q     <= '0;
        quo_q     <= w_dvd_abs;
        dvsr_q    <= w_dvs_abs;
        neg_quo_q <= w_dvd_neg ^ w_dvs_neg;
        neg_rem_q <= w_dvd_neg;
        is_rem_q  <= w_is_rem;
        rd_q      <= rd_addr_i;
      end
    end else if ((state_q == S_CALC) && !flush_i) begin
      cnt_q <= cnt_q + CW'(1);
      rem_q <= w_rem_nx;
      quo_q <= w_quo_nx;
      // Last iteration: sign-fix and publish in the same edge.
      if (cnt_q == C_LAST) begin
        result_q <= is_rem_q ? w_rem_fix : w_quo_fix;
        rd_out_q <= rd_q;
      end
    end
  end

  assign busy_o      = (state_q == S_CALC);
  assign valid_o     = (state_q == S_DONE);
  assign result_o    = result_q;
  assign rd_addr_o   = rd_out_q;
  assign stall_req_o = w_accept | (state_q == S_CALC);

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_unit
//  Purpose  : Self-checking bench for div_unit: directed RV32M cases, special
//             cases, flush, reset, and randomized back-to-back divides against
//             a plain-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [1:0]    op_i;
  logic [DW-1:0] dividend_i;
  logic [DW-1:0] divisor_i;
  logic [4:0]    rd_addr_i;
  logic          flush_i;
  logic          busy_o;
  logic          valid_o;
  logic [DW-1:0] result_o;
  logic [4:0]    rd_addr_o;
  logic          stall_req_o;

  int n_vec = 0;
  int n_err = 0;

  div_unit #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o),
    .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // RISC-V M-extension semantics with ordinary arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DW + 1;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    rd_addr_i  = rd;
  endtask

  // Called in cycle 0 (just after the edge). Returns at the negedge of the
  // valid cycle; inputs are scrambled after the start edge.
  task automatic observe(output int vcyc, output logic [31:0] res, output logic [4:0] rd,
                         output int busy_cnt, output int busy_first, output int stall_cnt,
                         output logic stall_at_v);
    vcyc = -1; res = '0; rd = '0; busy_cnt = 0; busy_first = -1;
    stall_cnt = 0; stall_at_v = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (busy_o) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
      end
      if (valid_o) begin
        vcyc = c; res = result_o; rd = rd_addr_o; stall_at_v = stall_req_o;
        return;
      end
      if (stall_req_o) stall_cnt++;
      @(posedge clk); #1;
      if (c == 0) begin
        start_i    = 1'b0;
        op_i       = 2'($urandom);
        dividend_i = $urandom;
        divisor_i  = $urandom;
        rd_addr_i  = 5'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
    dividend_i = '0; divisor_i = '0; rd_addr_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({busy_o, valid_o, stall_req_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {busy_o, valid_o, stall_req_o});
    end
    n_vec++;
    if (result_o !== 32'd0 || rd_addr_o !== 5'd0) begin
      n_err++; $display("FAIL reset_data: got %h/%0d want 0/0", result_o, rd_addr_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    vec_t v[2];
    int vc, bc, bf, sc; logic [31:0] r; logic [4:0] d; logic sv;
    v[0] = '{2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 33};
    v[1] = '{2'b11, 32'd100, 32'd7, 5'd5, 32'd2,  33};
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].rd);
      observe(vc, r, d, bc, bf, sc, sv);
      n_vec++;
      if (r !== v[i].exp || d !== v[i].rd) begin
        n_err++; $display("FAIL unsigned_%0d result: got %h rd %0d want %h rd %0d", i, r, d, v[i].exp, v[i].rd);
      end
      n_vec++;
      if (vc !== v[i].lat || bc !== 32 || bf !== 1) begin
        n_err++; $display("FAIL unsigned_%0d timing: got valid %0d busy %0d from %0d want 33/32/1", i, vc, bc, bf);
      end
      n_vec++;
      if (sc !== vc || sv !== 1'b0) begin
        n_err++; $display("FAIL unsigned_%0d stall: got %0d cycles, %b at valid want %0d, 0", i, sc, sv, vc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_signed();
    vec_t v[3];
    int vc, bc, bf, sc; logic [31:0] r; logic [4:0] d; logic sv;
    v[0] = '{2'b00, 32'hFFFF_FFF9, 32'd2,         5'd1, 32'hFFFF_FFFD, 33};
    v[1] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         5'd2, 32'hFFFF_FFFF, 33};
    v[2] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 5'd3, 32'd1,         33};
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].rd);
      observe(vc, r, d, bc, bf, sc, sv);
      n_vec++;
      if (r !== v[i].exp || d !== v[i].rd || vc !== v[i].lat) begin
        n_err++; $display("FAIL signed_%0d: got %h rd %0d cyc %0d want %h rd %0d cyc %0d", i, r, d, vc, v[i].exp, v[i].rd, v[i].lat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_special();
    vec_t v[4];
    int vc, bc, bf, sc; logic [31:0] r; logic [4:0] d; logic sv;
    v[0] = '{2'b01, 32'h1234,      32'd0,         5'd10, 32'hFFFF_FFFF, 1};
    v[1] = '{2'b10, 32'h1234,      32'd0,         5'd11, 32'h0000_1234, 1};
    v[2] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1};
    v[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1};
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].rd);
      observe(vc, r, d, bc, bf, sc, sv);
      n_vec++;
      if (r !== v[i].exp || d !== v[i].rd) begin
        n_err++; $display("FAIL special_%0d result: got %h rd %0d want %h rd %0d", i, r, d, v[i].exp, v[i].rd);
      end
      n_vec++;
      if (vc !== 1 || bc !== 0 || sc !== 1 || sv !== 1'b0) begin
        n_err++; $display("FAIL special_%0d timing: got valid %0d busy %0d stall %0d/%b want 1/0/1/0", i, vc, bc, sc, sv);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    int vc, bc, bf, sc; logic [31:0] r; logic [4:0] d; logic sv;
    logic saw_valid;
    // Known prior result.
    issue(2'b01, 32'd55, 32'd5, 5'd9);
    observe(vc, r, d, bc, bf, sc, sv);
    n_vec++;
    if (r !== 32'd11) begin
      n_err++; $display("FAIL flush_prior: got %h want 0000000b", r);
    end
    @(posedge clk); #1;
    // DIVU 1000/3 started in cycle 0, flushed in cycle 10.
    saw_valid = 1'b0;
    issue(2'b01, 32'd1000, 32'd3, 5'd4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (valid_o) saw_valid = 1'b1;
      @(posedge clk); #1;
      if (c + 1 == 1)  start_i = 1'b0;
      if (c + 1 == 10) flush_i = 1'b1;
    end
    @(negedge clk);
    if (valid_o) saw_valid = 1'b1;
    @(posedge clk); #1;
    // Cycle 11: back in IDLE, previous result intact; start DIVU 9/3.
    flush_i = 1'b0;
    issue(2'b01, 32'd9, 32'd3, 5'd7);
    #3;
    n_vec++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || saw_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_abort: got busy %b valid %b seen %b want 0 0 0", busy_o, valid_o, saw_valid);
    end
    n_vec++;
    if (result_o !== 32'd11 || rd_addr_o !== 5'd9) begin
      n_err++; $display("FAIL flush_hold: got %h rd %0d want 0000000b rd 9", result_o, rd_addr_o);
    end
    observe(vc, r, d, bc, bf, sc, sv);
    n_vec++;
    if (r !== 32'd3 || d !== 5'd7 || vc + 11 !== 44) begin
      n_err++; $display("FAIL flush_restart: got %h rd %0d cyc %0d want 3 rd 7 cyc 44", r, d, vc + 11);
    end
    @(posedge clk); #1;
    // Flush beats a same-cycle start in IDLE.
    issue(2'b01, 32'd50, 32'd5, 5'd8);
    flush_i = 1'b1;
    #3;
    n_vec++;
    if (stall_req_o !== 1'b0) begin
      n_err++; $display("FAIL flush_prio_stall: got %b want 0", stall_req_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0; start_i = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (valid_o || busy_o) saw_valid = 1'b1;
    end
    n_vec++;
    if (saw_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_prio: got activity %b want 0", saw_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic saw_valid;
    issue(2'b01, 32'd123456, 32'd7, 5'd21);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 0) start_i = 1'b0;
    end
    rst = 1'b1;                  // cycle 5
    @(posedge clk); #1;
    rst = 1'b0;                  // cycle 6
    #3;
    n_vec++;
    if ({busy_o, valid_o, stall_req_o} !== 3'b000 || result_o !== 32'd0 || rd_addr_o !== 5'd0) begin
      n_err++; $display("FAIL reset_mid: got %b %h %0d want 000 0 0", {busy_o, valid_o, stall_req_o}, result_o, rd_addr_o);
    end
    saw_valid = 1'b0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (valid_o) saw_valid = 1'b1;
    end
    n_vec++;
    if (saw_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_novalid: got %b want 0", saw_valid);
    end
    @(posedge clk); #1;
  endtask

  // Each divide starts in the cycle right after the previous valid_o.
  task automatic test_back_to_back();
    int vc, bc, bf, sc; logic [31:0] r; logic [4:0] d; logic sv;
    logic [1:0] op; logic [31:0] a, b, e; logic [4:0] rd; int lat;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      rd  = 5'($urandom);
      e   = ref_result(op, a, b);
      lat = ref_latency(op, a, b);
      issue(op, a, b, rd);
      observe(vc, r, d, bc, bf, sc, sv);
      n_vec++;
      if (r !== e || d !== rd || vc !== lat) begin
        n_err++; $display("FAIL rand_%0d op %0d %h/%h: got %h rd %0d cyc %0d want %h rd %0d cyc %0d", i, op, a, b, r, d, vc, e, rd, lat);
      end
      n_vec++;
      if (bc !== lat - 1 || sc !== lat || sv !== 1'b0) begin
        n_err++; $display("FAIL rand_%0d handshake: got busy %0d stall %0d/%b want %0d/%0d/0", i, bc, sc, sv, lat - 1, lat);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
